aximm_handshake_monitor: RTL and testbench
==========================================

# aximm_handshake_monitor

Passive observer on the five AXI-MM handshake channels (AW, W, B, AR, R) driven by the register-controlled master/slave handshake outputs. It counts completed handshakes per channel, tracks outstanding write and read transactions, and latches sticky protocol-violation flags. All results are registered outputs for readback or LED display. The block drives nothing on the observed bus.

## Interface
Parameters:
- CW, 16, per-channel handshake counter width.
- OW, 8, outstanding-transaction counter width.

Ports:
- clk  input  1  system clock.
- resetn  input  1  reset; asynchronous, active-low.
- valid  input  5  channel valids: [0]=awvalid, [1]=wvalid, [2]=bvalid, [3]=arvalid, [4]=rvalid.
- ready  input  5  channel readies, same bit order: awready, wready, bready, arready, rready.
- clear  input  1  synchronous clear pulse for counters and error flags.
- hs_count  output  5*CW  packed handshake counts; channel i occupies [i*CW +: CW].
- wr_outstanding  output  OW  number of AW handshakes not yet matched by a B handshake.
- rd_outstanding  output  OW  number of AR handshakes not yet matched by an R handshake.
- err  output  8  sticky flags.
  - [4:0] valid dropped before handshake, per channel.
  - [5] orphan B.
  - [6] orphan R.
  - [7] outstanding counter overflow.
- err_any  output  1  OR of err[7:0], registered.

## Operation
- Handshake on channel i when valid[i] & ready[i] are both high on a rising clk edge.
- hs_count[i]: +1 per handshake, saturating at 2^CW-1. Never wraps.
- Pending tracking:
  - pend[i] is registered each cycle as valid[i] & ~ready[i].
  - If pend[i]=1 and valid[i]=0 in the current cycle, set err[i] (valid withdrawn without handshake).
  - A handshake in the current cycle clears pending normally; no error.
- wr_outstanding:
  - +1 on AW handshake, -1 on B handshake.
  - Both in the same cycle: unchanged, including when the count is 0 (this is legal).
  - B handshake alone while the count is 0: count stays 0 and err[5] is set.
  - AW handshake alone while the count is 2^OW-1: count holds and err[7] is set.
- rd_outstanding: same rules with AR and R. Underflow sets err[6]; overflow sets err[7].
- Flags remain set until clear or reset.
- clear=1:
  - Next edge zeroes hs_count, both outstanding counters, err, and pend.
  - Events in the clear cycle are discarded; clear has priority.
- err_any follows err with one additional register stage.

## Timing
- Reset (asynchronous assert, synchronous use after release): hs_count=0, wr_outstanding=0, rd_outstanding=0, err=0, err_any=0, pend=0.
- Reset mid-operation clears everything immediately. A handshake present during the deassertion edge is not counted.
- Counters and err reflect a handshake or violation 1 cycle after the edge on which it occurs.
- err_any lags err by 1 cycle, so it lags the event by 2 cycles.
- Purely combinational paths from inputs to outputs: none.
- Every channel is evaluated independently each cycle. Simultaneous events on all five channels are all counted in that cycle.
- valid held high with ready low for any number of cycles: no error, no count.

## Test plan
- Reset, then hold valid=5'b11111 and ready=5'b11111 for 10 cycles.
  - Every hs_count field reads 10.
  - wr_outstanding=0, rd_outstanding=0, err=0.
- Stall-and-drop on AR:
  - arvalid=1, arready=0 for 3 cycles, then arvalid=0.
  - Next cycle err=8'h08; the cycle after, err_any=1.
  - hs_count[AR] stays 0.
- Outstanding writes:
  - 4 AW handshakes, then 4 B handshakes.
  - wr_outstanding sequence: 1,2,3,4,3,2,1,0; err=0.
  - One further B handshake: err[5]=1, wr_outstanding stays 0.
- Same-cycle AR and R handshakes with rd_outstanding=0: rd_outstanding remains 0, err[6]=0.
- Saturation:
  - CW=4: 20 W handshakes give hs_count[W]=15.
  - OW=2: 4 AR handshakes with no R give rd_outstanding=3 and err[7]=1.
- Clear and reset priority:
  - Assert clear in the same cycle as an AW handshake: all outputs read 0 afterwards.
  - Assert resetn low asynchronously between edges: outputs go to 0 before the next clk edge.

Source files
------------

// File: rtl/aximm_handshake_monitor.sv
// Passive AXI-MM handshake monitor: per-channel handshake counts, outstanding
// write/read tracking and sticky protocol-violation flags, all registered.

module aximm_hs_lane #(
    parameter int CW = 16
) (
    input  logic          clk,
    input  logic          resetn,
    input  logic          clear,
    input  logic          valid,
    input  logic          ready,
    output logic [CW-1:0] count,
    output logic          drop_err
);
    logic pend;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            pend     <= 1'b0;
            count    <= '0;
            drop_err <= 1'b0;
        end else if (clear) begin
            pend     <= 1'b0;
            count    <= '0;
            drop_err <= 1'b0;
        end else begin
            pend <= valid & ~ready;
            if (valid && ready && count != '1)
                count <= count + CW'(1);
            // valid was waiting last cycle and has now been withdrawn
            if (pend && !valid)
                drop_err <= 1'b1;
        end
    end
endmodule

module aximm_os_ctr #(
    parameter int OW = 8
) (
    input  logic          clk,
    input  logic          resetn,
    input  logic          clear,
    input  logic          inc,
    input  logic          dec,
    output logic [OW-1:0] cnt,
    output logic          ovf,
    output logic          unf
);
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            cnt <= '0;
            ovf <= 1'b0;
            unf <= 1'b0;
        end else if (clear) begin
            cnt <= '0;
            ovf <= 1'b0;
            unf <= 1'b0;
        end else begin
            // inc and dec together leave the count alone, even at zero
            case ({inc, dec})
                2'b10: if (cnt == '1) ovf <= 1'b1;
                       else           cnt <= cnt + OW'(1);
                2'b01: if (cnt == '0) unf <= 1'b1;
                       else           cnt <= cnt - OW'(1);
                default: ;
            endcase
        end
    end
endmodule

module aximm_handshake_monitor #(
    parameter int CW = 16,
    parameter int OW = 8
) (
    input  logic          clk,
    input  logic          resetn,
    input  logic [4:0]    valid,
    input  logic [4:0]    ready,
    input  logic          clear,
    output logic [5*CW-1:0] hs_count,
    output logic [OW-1:0] wr_outstanding,
    output logic [OW-1:0] rd_outstanding,
    output logic [7:0]    err,
    output logic          err_any
);
    localparam int NUM_CH = 5;

    logic [NUM_CH-1:0][CW-1:0] cnt;
    logic [NUM_CH-1:0]         drop;
    logic [NUM_CH-1:0]         hs;
    logic                      wr_ovf, wr_unf, rd_ovf, rd_unf;

    assign hs = valid & ready;

    for (genvar i = 0; i < NUM_CH; i++) begin : g_lane
        aximm_hs_lane #(.CW(CW)) u_lane (
            .clk      (clk),
            .resetn   (resetn),
            .clear    (clear),
            .valid    (valid[i]),
            .ready    (ready[i]),
            .count    (cnt[i]),
            .drop_err (drop[i])
        );
    end

    aximm_os_ctr #(.OW(OW)) u_wr (
        .clk(clk), .resetn(resetn), .clear(clear),
        .inc(hs[0]), .dec(hs[2]),
        .cnt(wr_outstanding), .ovf(wr_ovf), .unf(wr_unf)
    );

    aximm_os_ctr #(.OW(OW)) u_rd (
        .clk(clk), .resetn(resetn), .clear(clear),
        .inc(hs[3]), .dec(hs[4]),
        .cnt(rd_outstanding), .ovf(rd_ovf), .unf(rd_unf)
    );

    assign hs_count = cnt;
    assign err      = {wr_ovf | rd_ovf, rd_unf, wr_unf, drop};

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) err_any <= 1'b0;
        else         err_any <= |err;
    end
endmodule

// File: tb/tb_aximm_handshake_monitor.sv
// Bench for aximm_handshake_monitor: default instance plus a narrow CW=4/OW=2
// instance for saturation; expected values queued at drive time, popped on check.

module tb_aximm_handshake_monitor;
    localparam int CW = 16, OW = 8, SCW = 4, SOW = 2;

    logic clk = 1'b0, resetn = 1'b0;
    logic [4:0] valid = '0, ready = '0, valid_s = '0, ready_s = '0;
    logic clear = 1'b0, clear_s = 1'b0;

    logic [5*CW-1:0]  hs_count;
    logic [OW-1:0]    wr_outstanding, rd_outstanding;
    logic [7:0]       err;
    logic             err_any;
    logic [5*SCW-1:0] hs_count_s;
    logic [SOW-1:0]   wr_os_s, rd_os_s;
    logic [7:0]       err_s;
    logic             err_any_s;

    aximm_handshake_monitor #(.CW(CW), .OW(OW)) dut (
        .clk(clk), .resetn(resetn), .valid(valid), .ready(ready), .clear(clear),
        .hs_count(hs_count), .wr_outstanding(wr_outstanding),
        .rd_outstanding(rd_outstanding), .err(err), .err_any(err_any)
    );

    aximm_handshake_monitor #(.CW(SCW), .OW(SOW)) dut_s (
        .clk(clk), .resetn(resetn), .valid(valid_s), .ready(ready_s), .clear(clear_s),
        .hs_count(hs_count_s), .wr_outstanding(wr_os_s),
        .rd_outstanding(rd_os_s), .err(err_s), .err_any(err_any_s)
    );

    always #5 clk = ~clk;

    int vectors = 0, miscompares = 0;
    int unsigned expq[$];
    int unsigned e;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_clear();
        clear = 1'b1; clear_s = 1'b1;
        tick();
        clear = 1'b0; clear_s = 1'b0;
        tick();
    endtask

    task automatic test_reset();
        resetn = 1'b0;
        #2;
        for (int i = 0; i < 6; i++) expq.push_back(0);
        e = expq.pop_front(); vectors++;
        if (hs_count !== (5*CW)'(e)) begin miscompares++; $display("FAIL reset_hs: got %h want 0", hs_count); end
        e = expq.pop_front(); vectors++;
        if (wr_outstanding !== OW'(e) || rd_outstanding !== OW'(e)) begin
            miscompares++; $display("FAIL reset_os: got wr=%0d rd=%0d want 0", wr_outstanding, rd_outstanding); end
        e = expq.pop_front(); vectors++;
        if (err !== 8'(e)) begin miscompares++; $display("FAIL reset_err: got %h want 0", err); end
        e = expq.pop_front(); vectors++;
        if (err_any !== 1'(e)) begin miscompares++; $display("FAIL reset_err_any: got %b want 0", err_any); end
        e = expq.pop_front(); vectors++;
        if (hs_count_s !== (5*SCW)'(e)) begin miscompares++; $display("FAIL reset_hs_s: got %h want 0", hs_count_s); end
        e = expq.pop_front(); vectors++;
        if (err_s !== 8'(e) || rd_os_s !== SOW'(e)) begin
            miscompares++; $display("FAIL reset_s: got err=%h rd=%0d want 0", err_s, rd_os_s); end
        @(negedge clk) resetn = 1'b1;
        tick();
    endtask

    task automatic test_all_channels();
        valid = 5'h1f; ready = 5'h1f;
        for (int i = 0; i < 5; i++) expq.push_back(10);
        expq.push_back(0); expq.push_back(0); expq.push_back(0);
        repeat (10) tick();
        valid = '0; ready = '0;
        for (int i = 0; i < 5; i++) begin
            e = expq.pop_front(); vectors++;
            if (hs_count[i*CW +: CW] !== CW'(e)) begin
                miscompares++; $display("FAIL all_hs[%0d]: got %0d want %0d", i, hs_count[i*CW +: CW], e); end
        end
        e = expq.pop_front(); vectors++;
        if (wr_outstanding !== OW'(e)) begin miscompares++; $display("FAIL all_wr: got %0d want %0d", wr_outstanding, e); end
        e = expq.pop_front(); vectors++;
        if (rd_outstanding !== OW'(e)) begin miscompares++; $display("FAIL all_rd: got %0d want %0d", rd_outstanding, e); end
        e = expq.pop_front(); vectors++;
        if (err !== 8'(e)) begin miscompares++; $display("FAIL all_err: got %h want %h", err, e); end
    endtask

    task automatic test_stall_drop();
        valid = 5'b01000; ready = '0;
        repeat (3) tick();
        valid = '0;
        expq.push_back(8'h08); expq.push_back(0); expq.push_back(0); expq.push_back(1);
        tick();
        e = expq.pop_front(); vectors++;
        if (err !== 8'(e)) begin miscompares++; $display("FAIL drop_err: got %h want %h", err, e); end
        e = expq.pop_front(); vectors++;
        if (err_any !== 1'(e)) begin miscompares++; $display("FAIL drop_err_any_early: got %b want %0d", err_any, e); end
        e = expq.pop_front(); vectors++;
        if (hs_count[3*CW +: CW] !== CW'(e)) begin
            miscompares++; $display("FAIL drop_hs_ar: got %0d want %0d", hs_count[3*CW +: CW], e); end
        tick();
        e = expq.pop_front(); vectors++;
        if (err_any !== 1'(e)) begin miscompares++; $display("FAIL drop_err_any: got %b want %0d", err_any, e); end
    endtask

    task automatic test_outstanding();
        valid = 5'b00001; ready = 5'b00001;
        for (int k = 1; k <= 4; k++) begin
            expq.push_back(k);
            tick();
            e = expq.pop_front(); vectors++;
            if (wr_outstanding !== OW'(e)) begin miscompares++; $display("FAIL os_aw[%0d]: got %0d want %0d", k, wr_outstanding, e); end
        end
        valid = 5'b00100; ready = 5'b00100;
        for (int k = 3; k >= 0; k--) begin
            expq.push_back(k);
            tick();
            e = expq.pop_front(); vectors++;
            if (wr_outstanding !== OW'(e)) begin miscompares++; $display("FAIL os_b[%0d]: got %0d want %0d", k, wr_outstanding, e); end
        end
        expq.push_back(0);
        e = expq.pop_front(); vectors++;
        if (err !== 8'(e)) begin miscompares++; $display("FAIL os_err: got %h want %h", err, e); end
        expq.push_back(0); expq.push_back(8'h20);
        tick();
        valid = '0; ready = '0;
        e = expq.pop_front(); vectors++;
        if (wr_outstanding !== OW'(e)) begin miscompares++; $display("FAIL orphan_wr: got %0d want %0d", wr_outstanding, e); end
        e = expq.pop_front(); vectors++;
        if (err !== 8'(e)) begin miscompares++; $display("FAIL orphan_err: got %h want %h", err, e); end
    endtask

    task automatic test_same_cycle();
        valid = 5'b11000; ready = 5'b11000;
        expq.push_back(0); expq.push_back(0); expq.push_back(1);
        tick();
        valid = '0; ready = '0;
        e = expq.pop_front(); vectors++;
        if (rd_outstanding !== OW'(e)) begin miscompares++; $display("FAIL same_rd: got %0d want %0d", rd_outstanding, e); end
        e = expq.pop_front(); vectors++;
        if (err !== 8'(e)) begin miscompares++; $display("FAIL same_err: got %h want %h", err, e); end
        e = expq.pop_front(); vectors++;
        if (hs_count[4*CW +: CW] !== CW'(e)) begin miscompares++; $display("FAIL same_hs_r: got %0d want %0d", hs_count[4*CW +: CW], e); end
    endtask

    task automatic test_saturation();
        valid_s = 5'b00010; ready_s = 5'b00010;
        for (int k = 1; k <= 20; k++) begin
            tick();
            if (k == 15 || k == 20) begin
                expq.push_back(15);
                e = expq.pop_front(); vectors++;
                if (hs_count_s[1*SCW +: SCW] !== SCW'(e)) begin
                    miscompares++; $display("FAIL sat_w[%0d]: got %0d want %0d", k, hs_count_s[1*SCW +: SCW], e); end
            end
        end
        valid_s = 5'b01000; ready_s = 5'b01000;
        for (int k = 1; k <= 4; k++) begin
            expq.push_back(k < 3 ? k : 3);
            expq.push_back(k < 4 ? 0 : 8'h80);
            tick();
            e = expq.pop_front(); vectors++;
            if (rd_os_s !== SOW'(e)) begin miscompares++; $display("FAIL sat_rd[%0d]: got %0d want %0d", k, rd_os_s, e); end
            e = expq.pop_front(); vectors++;
            if (err_s !== 8'(e)) begin miscompares++; $display("FAIL sat_err[%0d]: got %h want %h", k, err_s, e); end
        end
        valid_s = '0; ready_s = '0;
        expq.push_back(1);
        tick();
        e = expq.pop_front(); vectors++;
        if (err_any_s !== 1'(e)) begin miscompares++; $display("FAIL sat_err_any: got %b want %0d", err_any_s, e); end
    endtask

    task automatic test_clear_priority();
        valid = 5'b00100; ready = 5'b00100;
        tick();
        valid = 5'b00001; ready = 5'b00001;
        expq.push_back(1);
        tick();
        e = expq.pop_front(); vectors++;
        if (err_any !== 1'(e)) begin miscompares++; $display("FAIL clr_pre_err_any: got %b want %0d", err_any, e); end
        clear = 1'b1;
        for (int i = 0; i < 5; i++) expq.push_back(0);
        tick();
        clear = 1'b0; valid = '0; ready = '0;
        e = expq.pop_front(); vectors++;
        if (hs_count !== (5*CW)'(e)) begin miscompares++; $display("FAIL clr_hs: got %h want 0", hs_count); end
        e = expq.pop_front(); vectors++;
        if (wr_outstanding !== OW'(e)) begin miscompares++; $display("FAIL clr_wr: got %0d want 0", wr_outstanding); end
        e = expq.pop_front(); vectors++;
        if (rd_outstanding !== OW'(e)) begin miscompares++; $display("FAIL clr_rd: got %0d want 0", rd_outstanding); end
        e = expq.pop_front(); vectors++;
        if (err !== 8'(e)) begin miscompares++; $display("FAIL clr_err: got %h want 0", err); end
        tick();
        e = expq.pop_front(); vectors++;
        if (err_any !== 1'(e)) begin miscompares++; $display("FAIL clr_err_any: got %b want 0", err_any); end
    endtask

    task automatic test_async_reset();
        valid = 5'b00001; ready = 5'b00001;
        valid_s = 5'b01000; ready_s = 5'b01000;
        expq.push_back(1);
        tick();
        valid = '0; ready = '0; valid_s = '0; ready_s = '0;
        e = expq.pop_front(); vectors++;
        if (wr_outstanding !== OW'(e)) begin miscompares++; $display("FAIL ar_pre_wr: got %0d want %0d", wr_outstanding, e); end
        #2 resetn = 1'b0;
        #1;
        for (int i = 0; i < 4; i++) expq.push_back(0);
        e = expq.pop_front(); vectors++;
        if (wr_outstanding !== OW'(e)) begin miscompares++; $display("FAIL ar_wr: got %0d want 0", wr_outstanding); end
        e = expq.pop_front(); vectors++;
        if (hs_count !== (5*CW)'(e)) begin miscompares++; $display("FAIL ar_hs: got %h want 0", hs_count); end
        e = expq.pop_front(); vectors++;
        if (rd_os_s !== SOW'(e) || hs_count_s !== (5*SCW)'(e)) begin
            miscompares++; $display("FAIL ar_s: got rd=%0d hs=%h want 0", rd_os_s, hs_count_s); end
        e = expq.pop_front(); vectors++;
        if (err_s !== 8'(e) || err_any_s !== 1'(e)) begin
            miscompares++; $display("FAIL ar_err_s: got err=%h any=%b want 0", err_s, err_any_s); end
        @(negedge clk) resetn = 1'b1;
        tick();
    endtask

    initial begin
        test_reset();
        test_all_channels();
        do_clear();
        test_stall_drop();
        do_clear();
        test_outstanding();
        do_clear();
        test_same_cycle();
        do_clear();
        test_saturation();
        test_clear_priority();
        test_async_reset();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
